// File: rtl/ling_pkg.sv
// Shared types and sizing helpers for the sequential Ling pseudo-carry generator.
// Chunk count is N/W; the chunk index is at least one bit wide, even when W == N.
package ling_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int num_chunks(input int n, input int w);
    return n / w;
  endfunction

  function automatic int idx_width(input int n, input int w);
    int c;
    c = n / w;
    return (c > 1) ? $clog2(c) : 1;
  endfunction

endpackage

// File: rtl/ling_hgen_seq_hchunk.sv
// One W-bit slice of the Ling recurrence, rippled combinationally from the incoming pseudo-carry.
// Zero latency; no handshake. The caller supplies t of the bit just below the slice.
module ling_hchunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] g_chunk,
  input  logic [W-1:0] t_chunk,
  input  logic         hn_in,
  input  logic         t_prev,
  output logic [W-1:0] h_chunk,
  output logic         hn_out
);

  // w_t_ext[j] is t of the bit just below slice bit j.
  logic [W:0] w_t_ext;
  assign w_t_ext = {t_chunk, t_prev};

  always_comb begin
    logic v_h;
    h_chunk = '0;
    v_h     = hn_in;
    for (int j = 0; j < W; j++) begin
      h_chunk[j] = v_h;
      v_h        = g_chunk[j] | (w_t_ext[j] & v_h);
    end
    hn_out = v_h;
  end

endmodule

// File: rtl/ling_hgen_seq.sv
// Sequential Ling pseudo-carry generator: resolves W bits of h per cycle, N/W cycles from accept to out_valid.
// Backpressure: h/p/g/cout are held in DONE until out_ready; in_ready is high only in IDLE.
module ling_hgen_seq
  import ling_pkg::*;
#(
  parameter int N = 64,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] h,
  output logic [N-1:0] p,
  output logic [N-1:0] g,
  output logic         cout
);

  localparam int NC = num_chunks(N, W);
  localparam int IW = idx_width(N, W);

  generate
    if ((W < 1) || (N % W != 0)) begin : g_bad_cfg
      $error("ling_hgen_seq: N must be a positive multiple of W");
    end
  endgenerate

  state_t        r_state;
  state_t        w_state_nxt;
  logic [IW-1:0] r_idx;
  logic [N-1:0]  r_h;
  logic [N-1:0]  r_p;
  logic [N-1:0]  r_g;
  logic          r_cout;
  logic          r_hn;
  logic          r_tlast;

  logic [N-1:0]  w_t;
  logic [31:0]   w_base;
  logic          w_last;
  logic [W-1:0]  w_g_chunk;
  logic [W-1:0]  w_t_chunk;
  logic [W-1:0]  w_h_chunk;
  logic          w_hn_out;

  assign w_t       = r_p | r_g;
  assign w_base    = 32'(r_idx) * 32'(W);
  assign w_last    = (r_idx == IW'(NC - 1));
  assign w_g_chunk = r_g[w_base +: W];
  assign w_t_chunk = w_t[w_base +: W];

  ling_hchunk #(.W(W)) u_hchunk (
    .g_chunk (w_g_chunk),
    .t_chunk (w_t_chunk),
    .hn_in   (r_hn),
    .t_prev  (r_tlast),
    .h_chunk (w_h_chunk),
    .hn_out  (w_hn_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_h     <= '0;
      r_p     <= '0;
      r_g     <= '0;
      r_cout  <= 1'b0;
      r_hn    <= 1'b0;
      r_tlast <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_p     <= a ^ b;
            r_g     <= a & b;
            r_hn    <= cin;
            r_tlast <= 1'b1;
            r_idx   <= '0;
          end
        end
        RUN: begin
          r_h[w_base +: W] <= w_h_chunk;
          r_hn             <= w_hn_out;
          r_tlast          <= w_t[w_base + W - 1];
          if (w_last) begin
            // w_hn_out here is the pseudo-carry out of bit N-1.
            r_cout <= w_t[N-1] & w_hn_out;
            r_idx  <= '0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign h    = r_h;
  assign p    = r_p;
  assign g    = r_g;
  assign cout = r_cout;

endmodule

// File: tb/tb_ling_hgen_seq.sv
// Bench for ling_hgen_seq at W=8, W=64 and W=1 (N=64); results are compared to plain a+b+cin arithmetic.
module tb_ling_hgen_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid  [3];
  logic        out_ready [3];
  logic        cin       [3];
  logic [63:0] a         [3];
  logic [63:0] b         [3];
  logic        in_ready  [3];
  logic        out_valid [3];
  logic        cout      [3];
  logic [63:0] h         [3];
  logic [63:0] p         [3];
  logic [63:0] g         [3];

  int errors = 0;
  int checks = 0;
  int lat_exp [3] = '{8, 1, 64};

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  always #5 clk = ~clk;

  ling_hgen_seq #(.N(64), .W(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0]), .b(b[0]), .cin(cin[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .h(h[0]), .p(p[0]), .g(g[0]), .cout(cout[0]));

  ling_hgen_seq #(.N(64), .W(64)) u_w64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1]), .b(b[1]), .cin(cin[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .h(h[1]), .p(p[1]), .g(g[1]), .cout(cout[1]));

  ling_hgen_seq #(.N(64), .W(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a[2]), .b(b[2]), .cin(cin[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .h(h[2]), .p(p[2]), .g(g[2]), .cout(cout[2]));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Downstream sum stage: s[i] = p[i] ^ (h[i] & t[i-1]), bit 0 uses t[-1] = 1.
  function automatic logic [64:0] sum_stage(input logic [63:0] hv, input logic [63:0] pv,
                                            input logic [63:0] gv, input logic cv);
    logic [63:0] t;
    t = pv | gv;
    return {cv, pv ^ (hv & {t[62:0], 1'b1})};
  endfunction

  function automatic logic [64:0] ref_sum(input logic [63:0] av, input logic [63:0] bv, input logic cv);
    return {1'b0, av} + {1'b0, bv} + 65'(cv);
  endfunction

  task automatic accept(input int k, input logic [63:0] av, input logic [63:0] bv, input logic cv);
    in_valid[k] = 1'b1;
    a[k] = av;
    b[k] = bv;
    cin[k] = cv;
    step();
    in_valid[k] = 1'b0;
    a[k] = {$urandom, $urandom};
    b[k] = ~bv;
    cin[k] = ~cv;
  endtask

  task automatic wait_valid(input int k, input bit chk_rdy, output int lat);
    lat = 0;
    while (!out_valid[k] && lat <= 200) begin
      if (chk_rdy) chk("in_ready_run", 65'(in_ready[k]), 65'(0));
      step();
      lat++;
    end
    if (chk_rdy) chk("in_ready_done", 65'(in_ready[k]), 65'(0));
  endtask

  task automatic check_result(input int k, input logic [63:0] av, input logic [63:0] bv, input logic cv);
    chk("p", 65'(p[k]), 65'(av ^ bv));
    chk("g", 65'(g[k]), 65'(av & bv));
    chk("sum", sum_stage(h[k], p[k], g[k], cout[k]), ref_sum(av, bv, cv));
  endtask

  task automatic release_out(input int k);
    out_ready[k] = 1'b1;
    step();
    out_ready[k] = 1'b0;
    chk("valid_drop", 65'(out_valid[k]), 65'(0));
    chk("ready_back", 65'(in_ready[k]), 65'(1));
  endtask

  task automatic run_random(input int k, input int nops);
    for (int i = 0; i < nops; i++) begin
      logic [63:0] av;
      logic [63:0] bv;
      logic        cv;
      int          mode;
      int          lat;
      int          tries;
      bit          hs;
      repeat ($urandom_range(0, 2)) step();
      mode = $urandom_range(0, 3);
      av = {$urandom, $urandom};
      if (mode == 0)      bv = ~av;
      else if (mode == 1) bv = {$urandom, $urandom} & 64'hF;
      else                bv = {$urandom, $urandom};
      cv = 1'($urandom_range(0, 1));
      chk("rnd_in_ready", 65'(in_ready[k]), 65'(1));
      accept(k, av, bv, cv);
      wait_valid(k, 1'b0, lat);
      chk("rnd_latency", 65'(lat), 65'(lat_exp[k]));
      check_result(k, av, bv, cv);
      tries = 0;
      hs = 1'b0;
      while (!hs) begin
        out_ready[k] = (tries >= 8) || ($urandom_range(0, 99) < 50);
        step();
        if (out_ready[k]) begin
          out_ready[k] = 1'b0;
          hs = 1'b1;
          chk("rnd_valid_drop", 65'(out_valid[k]), 65'(0));
          chk("rnd_ready_back", 65'(in_ready[k]), 65'(1));
        end else begin
          chk("rnd_hold_valid", 65'(out_valid[k]), 65'(1));
          chk("rnd_hold_sum", sum_stage(h[k], p[k], g[k], cout[k]), ref_sum(av, bv, cv));
        end
        tries++;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0;
      out_ready[k] = 1'b0;
      cin[k] = 1'b0;
      a[k] = '0;
      b[k] = '0;
    end
    #12;
    chk("rst_in_ready", 65'(in_ready[0]), 65'(1));
    chk("rst_out_valid", 65'(out_valid[0]), 65'(0));
    chk("rst_h", 65'(h[0]), 65'(0));
    chk("rst_p", 65'(p[0]), 65'(0));
    chk("rst_g", 65'(g[0]), 65'(0));
    chk("rst_cout", 65'(cout[0]), 65'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Zero operands, exact latency, in_ready low throughout.
    accept(0, 64'h0, 64'h0, 1'b0);
    wait_valid(0, 1'b1, lat);
    chk("t1_latency", 65'(lat), 65'(8));
    chk("t1_h", 65'(h[0]), 65'(0));
    chk("t1_p", 65'(p[0]), 65'(0));
    chk("t1_g", 65'(g[0]), 65'(0));
    chk("t1_cout", 65'(cout[0]), 65'(0));
    release_out(0);

    // All-ones plus carry-in ripples through every bit.
    accept(0, ONES, 64'h0, 1'b1);
    wait_valid(0, 1'b0, lat);
    chk("t2_latency", 65'(lat), 65'(8));
    chk("t2_h", 65'(h[0]), 65'(ONES));
    chk("t2_p", 65'(p[0]), 65'(ONES));
    chk("t2_g", 65'(g[0]), 65'(0));
    chk("t2_cout", 65'(cout[0]), 65'(1));
    chk("t2_sum", sum_stage(h[0], p[0], g[0], cout[0]), {1'b1, 64'h0});
    release_out(0);

    // Generate at bit 0 propagated to the top, then held under backpressure.
    accept(0, ONES, 64'h1, 1'b0);
    wait_valid(0, 1'b0, lat);
    chk("t3_latency", 65'(lat), 65'(8));
    chk("t3_h", 65'(h[0]), 65'(64'hFFFF_FFFF_FFFF_FFFE));
    chk("t3_p", 65'(p[0]), 65'(64'hFFFF_FFFF_FFFF_FFFE));
    chk("t3_g", 65'(g[0]), 65'(64'h1));
    chk("t3_cout", 65'(cout[0]), 65'(1));
    for (int i = 0; i < 10; i++) begin
      a[0] = {$urandom, $urandom};
      b[0] = {$urandom, $urandom};
      in_valid[0] = (i == 9);
      step();
      chk("t4_hold_valid", 65'(out_valid[0]), 65'(1));
      chk("t4_hold_h", 65'(h[0]), 65'(64'hFFFF_FFFF_FFFF_FFFE));
      chk("t4_hold_pg", {1'b0, p[0] ^ g[0]}, 65'(ONES));
      chk("t4_hold_cout", 65'(cout[0]), 65'(1));
    end
    // in_valid stays high across the output handshake; operand is taken one cycle later.
    a[0] = 64'h10;
    b[0] = 64'h20;
    cin[0] = 1'b1;
    out_ready[0] = 1'b1;
    step();
    out_ready[0] = 1'b0;
    chk("t4_valid_drop", 65'(out_valid[0]), 65'(0));
    chk("t4_ready_back", 65'(in_ready[0]), 65'(1));
    step();
    in_valid[0] = 1'b0;
    chk("t4_next_taken", 65'(in_ready[0]), 65'(0));
    wait_valid(0, 1'b0, lat);
    chk("t4_next_latency", 65'(lat), 65'(8));
    check_result(0, 64'h10, 64'h20, 1'b1);
    release_out(0);

    // Reset three cycles into an operation.
    accept(0, ONES, 64'h1, 1'b0);
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 65'(out_valid[0]), 65'(0));
    chk("t5_rst_h", 65'(h[0]), 65'(0));
    chk("t5_rst_p", 65'(p[0]), 65'(0));
    chk("t5_rst_g", 65'(g[0]), 65'(0));
    chk("t5_rst_cout", 65'(cout[0]), 65'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("t5_ready", 65'(in_ready[0]), 65'(1));
    accept(0, 64'd5, 64'd3, 1'b0);
    wait_valid(0, 1'b0, lat);
    chk("t5_latency", 65'(lat), 65'(8));
    chk("t5_h", 65'(h[0]), 65'(64'h1E));
    chk("t5_cout", 65'(cout[0]), 65'(0));
    chk("t5_sum", sum_stage(h[0], p[0], g[0], cout[0]), 65'd8);
    release_out(0);

    fork
      run_random(0, 1000);
      run_random(1, 1000);
      run_random(2, 400);
    join

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
